id_ex_stage: RTL and testbench

//  ID/EX pipeline stage feeding the ALU. Latches one decoded instruction per cycle and drives

---
 rtl/mips_pkg.sv | 35 +++
 rtl/hazard_fwd_unit.sv | 58 +++++
 rtl/id_ex_stage.sv | 187 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : opcode/function encodings and ID/EX stage FSM state type
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } st_e;

  // Instructions whose rt field is a source operand rather than a destination.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
// ============================================================================
// hazard_fwd_unit : operand forwarding muxes and load-use hazard detection
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module hazard_fwd_unit
  import mips_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            in_valid,
  input  logic [5:0]      op,
  input  logic [RA_W-1:0] rs_addr,
  input  logic [RA_W-1:0] rt_addr,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            exm_regwrite,
  input  logic [RA_W-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            mwb_regwrite,
  input  logic [RA_W-1:0] mwb_rd,
  input  logic [XLEN-1:0] mwb_result,
  input  logic            ex_valid,
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_dest,
  output logic [XLEN-1:0] rs_fwd,
  output logic [XLEN-1:0] rt_fwd,
  output logic            load_use
);

  // The younger EX/MEM result wins over MEM/WB; $0 always reads the register file.
  always_comb begin
    rs_fwd = rs_data;
    if (rs_addr != '0 && exm_regwrite && exm_rd == rs_addr)
      rs_fwd = exm_result;
    else if (rs_addr != '0 && mwb_regwrite && mwb_rd == rs_addr)
      rs_fwd = mwb_result;
  end

  always_comb begin
    rt_fwd = rt_data;
    if (rt_addr != '0 && exm_regwrite && exm_rd == rt_addr)
      rt_fwd = exm_result;
    else if (rt_addr != '0 && mwb_regwrite && mwb_rd == rt_addr)
      rt_fwd = mwb_result;
  end

  always_comb begin
    load_use = 1'b0;
    if (ex_valid && ex_mem_read && ex_dest != '0 && in_valid)
      load_use = (ex_dest == rs_addr) || (reads_rt(op) && ex_dest == rt_addr);
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : decode, hazard FSM and ID/EX pipeline register feeding the ALU
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module id_ex_stage
  import mips_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int LINK_REG = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            exm_regwrite,
  input  logic [RA_W-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            mwb_regwrite,
  input  logic [RA_W-1:0] mwb_rd,
  input  logic [XLEN-1:0] mwb_result,
  input  logic            flush,
  output logic            stall_out,
  output logic            out_valid,
  output logic [XLEN-1:0] firstVal,
  output logic [XLEN-1:0] secondVal,
  output logic [5:0]      opcode,
  output logic [5:0]      func,
  output logic [4:0]      sa,
  output logic [RA_W-1:0] dest_reg,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] store_data
);

  logic [5:0]      op;
  logic [5:0]      fn;
  logic [RA_W-1:0] rs_addr;
  logic [RA_W-1:0] rt_addr;
  logic [RA_W-1:0] rd_addr;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] imm_zext;

  assign op       = in_instr[31:26];
  assign fn       = in_instr[5:0];
  assign rs_addr  = in_instr[21 +: RA_W];
  assign rt_addr  = in_instr[16 +: RA_W];
  assign rd_addr  = in_instr[11 +: RA_W];
  assign imm_sext = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
  assign imm_zext = {{(XLEN-16){1'b0}}, in_instr[15:0]};

  logic [XLEN-1:0] rs_fwd;
  logic [XLEN-1:0] rt_fwd;
  logic            load_use;

  hazard_fwd_unit #(
    .XLEN (XLEN),
    .RA_W (RA_W)
  ) u_hazard_fwd (
    .in_valid     (in_valid),
    .op           (op),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .exm_regwrite (exm_regwrite),
    .exm_rd       (exm_rd),
    .exm_result   (exm_result),
    .mwb_regwrite (mwb_regwrite),
    .mwb_rd       (mwb_rd),
    .mwb_result   (mwb_result),
    .ex_valid     (out_valid),
    .ex_mem_read  (mem_read),
    .ex_dest      (dest_reg),
    .rs_fwd       (rs_fwd),
    .rt_fwd       (rt_fwd),
    .load_use     (load_use)
  );

  st_e state;
  st_e state_n;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = RUN;
    stall_out = 1'b0;
    if (!rst && !flush && state == RUN && load_use) begin
      state_n   = STALL;
      stall_out = 1'b1;
    end
  end

  logic [XLEN-1:0] d_a;
  logic [XLEN-1:0] d_b;
  logic [RA_W-1:0] d_dest;
  logic            d_we;
  logic            d_mr;
  logic            d_mw;

  always_comb begin
    d_a    = rs_fwd;
    d_b    = rt_fwd;
    d_dest = '0;
    d_we   = 1'b0;
    d_mr   = 1'b0;
    d_mw   = 1'b0;
    case (op)
      OP_RTYPE: begin
        d_dest = rd_addr;
        d_we   = (fn != FN_JR);
      end
      OP_ADDI, OP_ADDIU: begin
        d_b    = imm_sext;
        d_dest = rt_addr;
        d_we   = 1'b1;
      end
      OP_LW: begin
        d_b    = imm_sext;
        d_dest = rt_addr;
        d_we   = 1'b1;
        d_mr   = 1'b1;
      end
      OP_SW: begin
        d_b    = imm_sext;
        d_mw   = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        d_b    = imm_zext;
        d_dest = rt_addr;
        d_we   = 1'b1;
      end
      OP_JAL: begin
        d_a    = in_pc4;
        d_dest = RA_W'(LINK_REG);
        d_we   = 1'b1;
      end
      default: begin
        d_dest = '0;
      end
    endcase
  end

  // Flush, load-use and an empty IF/ID all produce an all-zero bubble.
  logic bubble;
  assign bubble = flush || load_use || !in_valid;

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      out_valid  <= 1'b0;
      firstVal   <= '0;
      secondVal  <= '0;
      opcode     <= '0;
      func       <= '0;
      sa         <= '0;
      dest_reg   <= '0;
      reg_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      store_data <= '0;
    end else begin
      out_valid  <= 1'b1;
      firstVal   <= d_a;
      secondVal  <= d_b;
      opcode     <= op;
      func       <= fn;
      sa         <= in_instr[10:6];
      dest_reg   <= d_dest;
      reg_write  <= d_we;
      mem_read   <= d_mr;
      mem_write  <= d_mw;
      store_data <= rt_fwd;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage : directed self-checking bench for id_ex_stage
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc4;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        exm_regwrite;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        mwb_regwrite;
  logic [4:0]  mwb_rd;
  logic [31:0] mwb_result;
  logic        flush;
  logic        stall_out;
  logic        out_valid;
  logic [31:0] firstVal;
  logic [31:0] secondVal;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [4:0]  sa;
  logic [4:0]  dest_reg;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] store_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .RA_W(5), .LINK_REG(31)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_pc4       (in_pc4),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .exm_regwrite (exm_regwrite),
    .exm_rd       (exm_rd),
    .exm_result   (exm_result),
    .mwb_regwrite (mwb_regwrite),
    .mwb_rd       (mwb_rd),
    .mwb_result   (mwb_result),
    .flush        (flush),
    .stall_out    (stall_out),
    .out_valid    (out_valid),
    .firstVal     (firstVal),
    .secondVal    (secondVal),
    .opcode       (opcode),
    .func         (func),
    .sa           (sa),
    .dest_reg     (dest_reg),
    .reg_write    (reg_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .store_data   (store_data)
  );

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_fwd();
    exm_regwrite = 1'b0; exm_rd = '0; exm_result = '0;
    mwb_regwrite = 1'b0; mwb_rd = '0; mwb_result = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_pc4 = 32'h4;
    in_instr = rtype(1, 2, 3, 6'h20); rs_data = 32'd5; rt_data = 32'd7;
    no_fwd();

    // Reset dominates a valid instruction.
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_a", firstVal, 32'd0);
    check("rst_b", secondVal, 32'd0);
    check("rst_dest", 32'(dest_reg), 32'd0);
    check("rst_we", 32'(reg_write), 32'd0);
    check("rst_stall", 32'(stall_out), 32'd0);

    // add $3,$1,$2 with no hazards
    rst = 1'b0;
    tick();
    check("add_a", firstVal, 32'd5);
    check("add_b", secondVal, 32'd7);
    check("add_dest", 32'(dest_reg), 32'd3);
    check("add_we", 32'(reg_write), 32'd1);
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_func", 32'(func), 32'h20);

    // add $4,$3,$3: EX/MEM beats MEM/WB, then MEM/WB alone
    in_instr = rtype(3, 3, 4, 6'h20); rs_data = 32'd100; rt_data = 32'd100;
    exm_regwrite = 1'b1; exm_rd = 5'd3; exm_result = 32'd12;
    mwb_regwrite = 1'b1; mwb_rd = 5'd3; mwb_result = 32'd9;
    tick();
    check("fwd_exm_a", firstVal, 32'd12);
    check("fwd_exm_b", secondVal, 32'd12);
    exm_rd = 5'd0;
    tick();
    check("fwd_mwb_a", firstVal, 32'd9);
    check("fwd_mwb_b", secondVal, 32'd9);

    // $0 is never forwarded
    in_instr = rtype(0, 0, 4, 6'h20); rs_data = 32'd0; rt_data = 32'd0;
    exm_rd = 5'd0; exm_result = 32'd55; mwb_rd = 5'd0; mwb_result = 32'd66;
    tick();
    check("fwd_r0_a", firstVal, 32'd0);
    check("fwd_r0_b", secondVal, 32'd0);
    no_fwd();

    // lw $5,4($0) then dependent add $6,$5,$1
    in_instr = itype(OP_LW, 0, 5, 16'd4); rs_data = 32'd0; rt_data = 32'd0;
    tick();
    check("lw_mr", 32'(mem_read), 32'd1);
    check("lw_dest", 32'(dest_reg), 32'd5);
    check("lw_b", secondVal, 32'd4);
    in_instr = rtype(5, 1, 6, 6'h20); rs_data = 32'd77; rt_data = 32'd5;
    #1;
    check("lu_stall", 32'(stall_out), 32'd1);
    tick();
    check("lu_bubble_valid", 32'(out_valid), 32'd0);
    check("lu_bubble_we", 32'(reg_write), 32'd0);
    check("lu_stall_clear", 32'(stall_out), 32'd0);
    tick();
    check("lu_accept_valid", 32'(out_valid), 32'd1);
    check("lu_accept_dest", 32'(dest_reg), 32'd6);
    check("lu_accept_a", firstVal, 32'd77);

    // lw followed by an I-type whose rt is only a destination: no hazard
    in_instr = itype(OP_LW, 0, 5, 16'd4); rs_data = 32'd0;
    tick();
    in_instr = itype(OP_ADDI, 1, 5, 16'd3); rs_data = 32'd5;
    #1;
    check("lu_rt_dest_nostall", 32'(stall_out), 32'd0);

    // Flush overrides a concurrent load-use
    in_instr = itype(OP_LW, 0, 5, 16'd4); rs_data = 32'd0;
    tick();
    in_instr = itype(OP_ADDI, 5, 7, 16'd1); rs_data = 32'd1;
    #1;
    check("fl_pre_stall", 32'(stall_out), 32'd1);
    flush = 1'b1;
    #1;
    check("fl_stall", 32'(stall_out), 32'd0);
    tick();
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_we", 32'(reg_write), 32'd0);
    flush = 1'b0;
    in_instr = rtype(1, 2, 8, 6'h20); rs_data = 32'd5; rt_data = 32'd7;
    #1;
    check("fl_run_stall", 32'(stall_out), 32'd0);
    tick();
    check("fl_run_valid", 32'(out_valid), 32'd1);
    check("fl_run_dest", 32'(dest_reg), 32'd8);

    // Immediates and jal
    in_instr = itype(OP_ADDI, 1, 9, 16'hFFFE); rs_data = 32'd5;
    tick();
    check("addi_b", secondVal, 32'hFFFF_FFFE);
    check("addi_dest", 32'(dest_reg), 32'd9);
    in_instr = itype(OP_ORI, 1, 9, 16'hFFFE);
    tick();
    check("ori_b", secondVal, 32'h0000_FFFE);
    in_instr = {OP_JAL, 26'h10}; in_pc4 = 32'h40; rs_data = 32'd0;
    tick();
    check("jal_a", firstVal, 32'h40);
    check("jal_dest", 32'(dest_reg), 32'd31);
    check("jal_we", 32'(reg_write), 32'd1);

    // sw $2,8($1), jr, unknown opcode
    in_instr = itype(OP_SW, 1, 2, 16'd8); rs_data = 32'd10; rt_data = 32'd33;
    tick();
    check("sw_mw", 32'(mem_write), 32'd1);
    check("sw_we", 32'(reg_write), 32'd0);
    check("sw_data", store_data, 32'd33);
    check("sw_b", secondVal, 32'd8);
    in_instr = rtype(31, 0, 0, FN_JR);
    tick();
    check("jr_we", 32'(reg_write), 32'd0);
    in_instr = {6'h3F, 26'h0};
    tick();
    check("unk_valid", 32'(out_valid), 32'd1);
    check("unk_we", 32'(reg_write | mem_read | mem_write), 32'd0);
    check("unk_op", 32'(opcode), 32'h3F);

    // Reset during a load-use stall
    in_instr = itype(OP_LW, 0, 5, 16'd4); rs_data = 32'd0;
    tick();
    in_instr = rtype(5, 1, 6, 6'h20); rs_data = 32'd77; rt_data = 32'd5;
    #1;
    check("rs_pre_stall", 32'(stall_out), 32'd1);
    rst = 1'b1;
    #1;
    check("rs_stall", 32'(stall_out), 32'd0);
    tick();
    check("rs_valid", 32'(out_valid), 32'd0);
    check("rs_a", firstVal, 32'd0);
    check("rs_mr", 32'(mem_read), 32'd0);
    check("rs_dest", 32'(dest_reg), 32'd0);
    rst = 1'b0;
    #1;
    check("rs_run_stall", 32'(stall_out), 32'd0);
    tick();
    check("rs_run_valid", 32'(out_valid), 32'd1);
    check("rs_run_a", firstVal, 32'd77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
